// File: rtl/decode_regread_pkg.sv
// Shared widths and helpers for the decode/register-read stage.
package decode_regread_pkg;

  localparam int XLEN       = 32;
  localparam int PC_W       = 8;
  localparam int IMM_W      = 12;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  function automatic logic [XLEN-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/decode_regread_regfile.sv
// 32 x XLEN architectural register file: one write port, two combinational
// read ports that see a same-cycle write, x0 hardwired to zero.
module regfile_2r1w
  import decode_regread_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic [XLEN-1:0]       rs1_val_o,
  output logic [XLEN-1:0]       rs2_val_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_en_i && (wb_rd_i != '0)) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  always_comb begin
    rs1_val_o = regs_q[rs1_i];
    if (rs1_i == '0) rs1_val_o = '0;
    else if (wb_en_i && (wb_rd_i == rs1_i)) rs1_val_o = wb_data_i;

    rs2_val_o = regs_q[rs2_i];
    if (rs2_i == '0) rs2_val_o = '0;
    else if (wb_en_i && (wb_rd_i == rs2_i)) rs2_val_o = wb_data_i;
  end

endmodule

// File: rtl/decode_regread.sv
// Register-read stage: bypassed operand read into a one-entry valid/ready slot,
// 1-cycle latency; stalls via in_ready, held operands track write-back while stalled.
module decode_regread
  import decode_regread_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [IMM_W-1:0]      in_imm,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_rs1_val,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [XLEN-1:0]       out_imm
);

  logic [XLEN-1:0]       rs1_rd_val, rs2_rd_val;
  logic                  vld_q, vld_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [REG_ADDR_W-1:0] rs1_idx_q, rs1_idx_d, rs2_idx_q, rs2_idx_d;
  logic [XLEN-1:0]       rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic                  capture, refresh;

  regfile_2r1w u_regfile (
    .clk       (clk),
    .rst_n     (reset),
    .wb_en_i   (wb_en),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .rs1_val_o (rs1_rd_val),
    .rs2_val_o (rs2_rd_val)
  );

  assign in_ready = ~vld_q | out_ready;
  assign capture  = in_valid & in_ready & ~flush;
  // A stalled slot would otherwise hold operands that write-back has since made stale.
  assign refresh  = vld_q & ~out_ready & ~flush & wb_en & (wb_rd != '0);

  always_comb begin
    vld_d     = vld_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;

    if (capture) begin
      pc_d      = in_pc;
      rd_d      = in_rd;
      rs1_idx_d = in_rs1;
      rs2_idx_d = in_rs2;
      rs1_val_d = rs1_rd_val;
      rs2_val_d = rs2_rd_val;
      imm_d     = sign_extend_imm(in_imm);
    end else if (refresh) begin
      if (wb_rd == rs1_idx_q) rs1_val_d = wb_data;
      if (wb_rd == rs2_idx_q) rs2_val_d = wb_data;
    end

    if (flush)          vld_d = 1'b0;
    else if (capture)   vld_d = 1'b1;
    else if (out_ready) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= 1'b0;
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_idx_q <= '0;
      rs2_idx_q <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
    end else begin
      vld_q     <= vld_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      rs1_idx_q <= rs1_idx_d;
      rs2_idx_q <= rs2_idx_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
    end
  end

  assign out_valid   = vld_q;
  assign out_pc      = pc_q;
  assign out_rd      = rd_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_imm     = imm_q;

endmodule

// File: tb/tb_decode_regread.sv
// Scoreboard bench for decode_regread: a reference model predicts each slot entry.
module tb_decode_regread;
  import decode_regread_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_pc;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [7:0]  out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm;

  always #5 clk = ~clk;

  decode_regread dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [4:0]  rd;
    logic [4:0]  rs1i;
    logic [4:0]  rs2i;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic        m_vld;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  task automatic check_slot(input string pfx);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({pfx, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb[0];
    check_eq({pfx, "_pc"},  32'(out_pc), 32'(e.pc));
    check_eq({pfx, "_rd"},  32'(out_rd), 32'(e.rd));
    check_eq({pfx, "_rs1"}, out_rs1_val, e.a);
    check_eq({pfx, "_rs2"}, out_rs2_val, e.b);
    check_eq({pfx, "_imm"}, out_imm, e.imm);
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  task automatic tick();
    exp_t e;
    logic cap, rdy;
    #1;
    rdy = !m_vld || out_ready;
    check_eq("in_ready", 32'(in_ready), 32'(rdy));
    cap = in_valid && rdy && !flush;
    if (m_vld && out_ready) check_slot("drain");
    if (m_vld && (out_ready || flush) && sb.size() > 0) void'(sb.pop_front());
    if (m_vld && !out_ready && !flush && wb_en && wb_rd != 5'd0 && sb.size() > 0) begin
      e = sb[0];
      if (e.rs1i == wb_rd) e.a = wb_data;
      if (e.rs2i == wb_rd) e.b = wb_data;
      sb[0] = e;
    end
    if (cap) begin
      e.pc   = in_pc;
      e.rd   = in_rd;
      e.rs1i = in_rs1;
      e.rs2i = in_rs2;
      e.a    = m_read(in_rs1);
      e.b    = m_read(in_rs2);
      e.imm  = 32'($signed(in_imm));
      sb.push_back(e);
    end
    if (flush)          m_vld = 1'b0;
    else if (cap)       m_vld = 1'b1;
    else if (out_ready) m_vld = 1'b0;
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    @(posedge clk);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) check_slot("slot");
  endtask

  task automatic set_in(input logic v, input logic [7:0] pc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    in_valid = v; in_pc = pc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_en = en; wb_rd = rd; wb_data = data;
  endtask

  task automatic idle();
    set_in(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 12'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    #3;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_pc", 32'(out_pc), 32'd0);
    check_eq("rst_out_rd", 32'(out_rd), 32'd0);
    check_eq("rst_rs1", out_rs1_val, 32'd0);
    check_eq("rst_rs2", out_rs2_val, 32'd0);
    check_eq("rst_imm", out_imm, 32'd0);
    #9 reset = 1'b1;

    // Fresh register file reads zero
    set_in(1'b1, 8'd1, 5'd1, 5'd5, 5'd31, 12'd0); tick();
    check_eq("idle_read_rs1", out_rs1_val, 32'd0);
    check_eq("idle_read_rs2", out_rs2_val, 32'd0);
    idle(); tick();

    // Write then read
    set_wb(1'b1, 5'd3, 32'hDEADBEEF); tick();
    idle(); set_in(1'b1, 8'd2, 5'd2, 5'd3, 5'd0, 12'h7FF); tick();
    check_eq("wr_then_rd", out_rs1_val, 32'hDEADBEEF);
    check_eq("imm_pos", out_imm, 32'h0000_07FF);

    // Same-cycle bypass, x0, negative immediate
    set_wb(1'b1, 5'd7, 32'h12345678); set_in(1'b1, 8'd3, 5'd3, 5'd7, 5'd0, 12'h800); tick();
    check_eq("bypass_rs1", out_rs1_val, 32'h12345678);
    check_eq("bypass_x0", out_rs2_val, 32'd0);
    check_eq("imm_neg", out_imm, 32'hFFFF_F800);
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF); set_in(1'b1, 8'd4, 5'd4, 5'd0, 5'd0, 12'h7FF); tick();
    idle(); set_in(1'b1, 8'd5, 5'd5, 5'd0, 5'd7, 12'h123); tick();
    check_eq("x0_write_ignored", out_rs1_val, 32'd0);
    idle(); tick();

    // Stall with refresh, then drain+capture on the same edge
    set_in(1'b1, 8'd10, 5'd10, 5'd3, 5'd9, 12'h001); tick();
    out_ready = 1'b0; set_in(1'b1, 8'd20, 5'd20, 5'd9, 5'd7, 12'hF00); tick();
    check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    check_eq("stall_hold_pc", 32'(out_pc), 32'd10);
    set_wb(1'b1, 5'd9, 32'hA5A5A5A5); tick();
    check_eq("refresh_rs2", out_rs2_val, 32'hA5A5A5A5);
    set_wb(1'b0, 5'd0, 32'd0); out_ready = 1'b1; tick();
    check_eq("swap_pc", 32'(out_pc), 32'd20);
    check_eq("swap_rs1", out_rs1_val, 32'hA5A5A5A5);
    set_in(1'b1, 8'd21, 5'd21, 5'd7, 5'd9, 12'h0AA); tick();

    // Flush beats capture and drain; write-back still lands
    flush = 1'b1; set_in(1'b1, 8'd30, 5'd1, 5'd1, 5'd1, 12'd0); set_wb(1'b1, 5'd4, 32'h44); tick();
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    idle(); set_in(1'b1, 8'd31, 5'd1, 5'd4, 5'd3, 12'd0); tick();
    check_eq("wb_during_flush", out_rs1_val, 32'h44);

    // Reset in the middle of a stall
    out_ready = 1'b0; set_in(1'b0, 8'd0, 5'd0, 5'd0, 5'd0, 12'd0); tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_rs1", out_rs1_val, 32'd0);
    model_reset();
    #1 reset = 1'b1;
    idle(); set_in(1'b1, 8'd40, 5'd2, 5'd4, 5'd3, 12'd0); tick();
    check_eq("post_rst_capture", 32'(out_valid), 32'd1);
    check_eq("post_rst_regs_clear", out_rs1_val, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 200; i++) begin
      set_in(1'($urandom_range(0, 1)), 8'($urandom), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_regread.md
Name: decode_regread

Overview:
- Stage directly downstream of the PC/fetch/decode top.
- Accepts decoded fields (pc, rd, rs1, rs2, imm[11:0]) and reads a 32x32 register file with write-back bypass.
- Registers the operands into a one-entry valid/ready pipeline slot feeding execute.
- Owns the architectural register file, written by the write-back stage.

Parameters:
- XLEN, 32, register and operand width.
- PC_W, 8, program counter width.
- IMM_W, 12, raw immediate width from decode.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  PC_W  pc of instruction.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_imm  input  IMM_W  raw immediate.
- wb_en  input  1  write-back strobe.
- wb_rd  input  5  write-back destination.
- wb_data  input  XLEN  write-back value.
- flush  input  1  discard held and incoming instruction.
- out_valid  output  1  slot holds a valid instruction.
- out_ready  input  1  execute accepts this cycle.
- out_pc  output  PC_W.
- out_rd  output  5.
- out_rs1_val, out_rs2_val  output  XLEN  operand values.
- out_imm  output  XLEN  sign-extended immediate.

Behaviour:
- Reset (reset=0, asynchronous): all 32 registers = 0; out_valid = 0; out_pc, out_rd, out_rs1_val, out_rs2_val, out_imm = 0.
- Register file write: on clk rising edge when wb_en=1 and wb_rd != 0, regs[wb_rd] <= wb_data. A write with wb_rd = 0 is ignored; x0 always reads 0.
- Read is combinational, with same-cycle bypass. Operand rsN value:
  - 0 if rsN = 0;
  - wb_data if wb_en=1 and wb_rd = rsN;
  - regs[rsN] otherwise.
- Ready: in_ready = ~out_valid | out_ready. It is combinational and does not depend on in_valid.
- Capture: when in_valid & in_ready & ~flush, the slot loads pc, rd, bypassed operands, and sign-extended imm (bit 11 replicated to bits 31:12) on the next edge. out_valid = 1. Latency is 1 cycle.
- Drain: when out_valid & out_ready and no capture occurs, out_valid <= 0. Payload holds its last value.
- Stall refresh:
  - While out_valid=1 and out_ready=0, the slot keeps stored rs1/rs2 indices (internal).
  - If wb_en=1 and wb_rd != 0 matches a stored index, that operand is updated to wb_data on the edge.
  - Both operands update if both indices match.
- Flush: flush=1 gives out_valid <= 0 on the next edge and blocks capture that cycle. It has priority over capture and drain. Register-file writes still occur.
- Simultaneous drain and capture: new instruction replaces old in the same edge, with no bubble.
- Back-to-back dependency (write-back of rd in cycle N, read of the same reg in cycle N) returns the new value via bypass.
- Reset asserted mid-stall: the slot is dropped immediately and the register file is cleared. The first edge after release accepts a new instruction.

Decomposition:
- Shared package: XLEN, PC_W, IMM_W, REG_ADDR_W=5, NUM_REGS=32, and a sign_extend_imm function.
- One sub-module, regfile_2r1w: 32xXLEN, async active-low clear, two combinational read ports with write bypass and x0 hardwiring.
- Pipeline slot, ready logic, and stall refresh live in decode_regread.

Test Plan:
- Reset then idle: after reset release, out_valid=0 and all outputs 0. A read of rs1=5, rs2=31 gives 0 and 0 once captured.
- Write-then-read: wb_en=1, wb_rd=3, wb_data=0xDEADBEEF in cycle 0. Capture rs1=3 in cycle 1 gives out_rs1_val=0xDEADBEEF in cycle 2.
- Bypass and x0: in one cycle wb_rd=7, data=0x12345678 with in_rs1=7, in_rs2=0. Next cycle out_rs1_val=0x12345678, out_rs2_val=0. A separate wb_rd=0, data=0xFFFFFFFF leaves x0 reading 0.
- Immediate sign-extension: in_imm=0x800 gives out_imm=0xFFFFF800; in_imm=0x7FF gives 0x000007FF.
- Stall and refresh:
  - Hold out_ready=0 with slot rs2=9; in_ready=0 and the new in_valid instruction is not accepted.
  - wb_rd=9, data=0xA5A5A5A5 gives out_rs2_val=0xA5A5A5A5 next cycle.
  - On out_ready=1 the held instruction drains and the pending one captures the same edge.
- Flush priority: out_valid=1, flush=1, in_valid=1, out_ready=1 in the same cycle gives out_valid=0 next cycle. Asserting reset=0 mid-stall gives out_valid=0 immediately.
